gic_reg_block: RTL and testbench

//  Register bank and interrupt core behind the 8-bit-address / 32-bit-data register bus.
//  - Decodes wr_en/rd_en accesses and holds enable, trigger, priority and threshold state.
//  - Latches pending sources and arbitrates one winner.
//  - Drives the CPU interrupt line and implements the claim/EOI protocol.

---
 rtl/gic_pkg.sv | 20 ++
 rtl/gic_reg_block_if.sv | 13 +
 rtl/gic_prio_arbiter.sv | 31 +++
 rtl/gic_reg_block.sv | 157 +++++++++++++++
 tb/tb_gic_reg_block.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gic_pkg.sv
// Shared definitions for the interrupt register block: register offsets,
// default priority width and the claim ID type.
package gic_pkg;

  localparam int PRIO_W_DEF = 4;
  localparam int ID_W       = 6;

  localparam logic [7:0] OFF_CTRL      = 8'h00;
  localparam logic [7:0] OFF_ENABLE    = 8'h04;
  localparam logic [7:0] OFF_PENDING   = 8'h08;
  localparam logic [7:0] OFF_TRIGGER   = 8'h0C;
  localparam logic [7:0] OFF_CLAIM     = 8'h10;
  localparam logic [7:0] OFF_ACTIVE    = 8'h14;
  localparam logic [7:0] OFF_THRESH    = 8'h18;
  localparam logic [7:0] OFF_PRIO_BASE = 8'h20;

  // Claim IDs are source index + 1 so that 0 can mean "no interrupt".
  typedef logic [ID_W-1:0] claim_id_t;

endpackage

// File: rtl/gic_reg_block_if.sv
// Register bus between a CPU-side master and the interrupt register block.
interface gic_reg_block_if;

  logic [7:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output wr_en, output rd_en, output wdata, input rdata);
  modport slave  (input addr, input wr_en, input rd_en, input wdata, output rdata);

endinterface

// File: rtl/gic_prio_arbiter.sv
// Combinational priority arbiter: highest priority candidate wins, ties go
// to the lowest source index.
module gic_prio_arbiter
  import gic_pkg::*;
#(
  parameter int NUM_IRQ = 16,
  parameter int PRIO_W  = PRIO_W_DEF
) (
  input  logic [NUM_IRQ-1:0]        cand,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio_flat,
  output logic                      win_vld,
  output claim_id_t                 win_idx
);

  logic [PRIO_W-1:0] best;

  // Strict greater-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    best    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cand[i] && (!win_vld || (prio_flat[i*PRIO_W +: PRIO_W] > best))) begin
        win_vld = 1'b1;
        win_idx = claim_id_t'(i);
        best    = prio_flat[i*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/gic_reg_block.sv
// Interrupt controller register bank: bus decode, pending/active state,
// claim/EOI and registered CPU outputs. GIC_IRQ_SYNC_EN adds 2-flop source sync.
module gic_reg_block
  import gic_pkg::*;
#(
  parameter int NUM_IRQ = 16,
  parameter int PRIO_W  = PRIO_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  gic_reg_block_if.slave     bus,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq_out,
  output claim_id_t          irq_id
);

  localparam logic [5:0] W_CTRL    = OFF_CTRL[7:2];
  localparam logic [5:0] W_ENABLE  = OFF_ENABLE[7:2];
  localparam logic [5:0] W_PENDING = OFF_PENDING[7:2];
  localparam logic [5:0] W_TRIGGER = OFF_TRIGGER[7:2];
  localparam logic [5:0] W_CLAIM   = OFF_CLAIM[7:2];
  localparam logic [5:0] W_ACTIVE  = OFF_ACTIVE[7:2];
  localparam logic [5:0] W_THRESH  = OFF_THRESH[7:2];
  localparam logic [5:0] W_PRIO    = OFF_PRIO_BASE[7:2];

  logic                      ctrl;
  logic [NUM_IRQ-1:0]        enable, trig, pend, act;
  logic [PRIO_W-1:0]         thresh;
  logic [PRIO_W-1:0]         prio [NUM_IRQ];
  logic [NUM_IRQ*PRIO_W-1:0] prio_flat;
  logic [NUM_IRQ-1:0]        src_s, src_q, rise;
  logic [NUM_IRQ-1:0]        cand, pend_n, act_n;
  logic [NUM_IRQ-1:0]        w1c_vec, flip_vec, eoi_vec, claim_vec;
  logic [5:0]                widx, pk;
  logic                      wr_claim, claim_fire, win_vld;
  claim_id_t                 win_idx, win_id1;
  logic [31:0]               rd_val;
  logic                      unused_addr_lsb;

  assign widx            = bus.addr[7:2];
  assign pk              = widx - W_PRIO;
  assign unused_addr_lsb = ^bus.addr[1:0];

`ifdef GIC_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  assign src_s = irq_src;
`endif

  // src_q is the previous sample; pending itself samples src_s directly.
  assign rise = src_s & ~src_q;

  always_comb begin
    prio_flat = '0;
    cand      = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      prio_flat[i*PRIO_W +: PRIO_W] = prio[i];
      cand[i] = pend[i] & enable[i] & ~act[i] & (prio[i] > thresh);
    end
  end

  gic_prio_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .PRIO_W  (PRIO_W)
  ) u_arb (
    .cand      (cand),
    .prio_flat (prio_flat),
    .win_vld   (win_vld),
    .win_idx   (win_idx)
  );

  assign win_id1    = win_idx + claim_id_t'(1);
  assign wr_claim   = bus.wr_en && (widx == W_CLAIM);
  assign claim_fire = bus.rd_en && (widx == W_CLAIM) && win_vld;
  assign w1c_vec    = (bus.wr_en && (widx == W_PENDING)) ? bus.wdata[NUM_IRQ-1:0] : '0;
  assign flip_vec   = (bus.wr_en && (widx == W_TRIGGER)) ? (bus.wdata[NUM_IRQ-1:0] ^ trig) : '0;

  // Pending/active next state: edge sets beat W1C and claim, a trigger flip beats all.
  always_comb begin
    eoi_vec   = '0;
    claim_vec = '0;
    pend_n    = pend;
    for (int i = 0; i < NUM_IRQ; i++) begin
      eoi_vec[i]   = wr_claim && (bus.wdata == 32'(i + 1));
      claim_vec[i] = claim_fire && (win_idx == claim_id_t'(i));
      if (trig[i]) pend_n[i] = (pend[i] & ~w1c_vec[i] & ~claim_vec[i]) | rise[i];
      else         pend_n[i] = src_s[i];
    end
    pend_n = pend_n & ~flip_vec;
    act_n  = (act & ~eoi_vec) | claim_vec;
  end

  always_comb begin
    rd_val = '0;
    case (widx)
      W_CTRL:    rd_val = {31'b0, ctrl};
      W_ENABLE:  rd_val = 32'(enable);
      W_PENDING: rd_val = 32'(pend);
      W_TRIGGER: rd_val = 32'(trig);
      W_CLAIM:   rd_val = win_vld ? 32'(win_id1) : 32'd0;
      W_ACTIVE:  rd_val = 32'(act);
      W_THRESH:  rd_val = 32'(thresh);
      default: begin
        // Below 0x20 pk wraps to 56..63 and never matches a source word.
        for (int i = 0; i < NUM_IRQ; i++)
          if (pk == 6'(i / 8)) rd_val[4*(i%8) +: PRIO_W] = prio[i];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl    <= 1'b0;
      enable  <= '0;
      trig    <= '0;
      thresh  <= '0;
      pend    <= '0;
      act     <= '0;
      src_q   <= '0;
      bus.rdata <= '0;
      irq_out <= 1'b0;
      irq_id  <= '0;
      for (int i = 0; i < NUM_IRQ; i++) prio[i] <= '0;
    end else begin
      src_q   <= src_s;
      pend    <= pend_n;
      act     <= act_n;
      irq_out <= ctrl & win_vld;
      irq_id  <= win_vld ? win_id1 : '0;
      if (bus.rd_en) bus.rdata <= rd_val;
      if (bus.wr_en) begin
        case (widx)
          W_CTRL:    ctrl   <= bus.wdata[0];
          W_ENABLE:  enable <= bus.wdata[NUM_IRQ-1:0];
          W_TRIGGER: trig   <= bus.wdata[NUM_IRQ-1:0];
          W_THRESH:  thresh <= bus.wdata[PRIO_W-1:0];
          default: ;
        endcase
        for (int i = 0; i < NUM_IRQ; i++)
          if (pk == 6'(i / 8)) prio[i] <= bus.wdata[4*(i%8) +: PRIO_W];
      end
    end
  end

endmodule

// File: tb/tb_gic_reg_block.sv
// Scoreboard bench for gic_reg_block: directed scenarios then random traffic,
// checked against a register-level reference model.
module tb_gic_reg_block;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq_src;
  logic         irq_out;
  logic [5:0]   irq_id;

  always #5 clk = ~clk;

  gic_reg_block_if bus();

  gic_reg_block #(.NUM_IRQ(N), .PRIO_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .irq_src (irq_src),
    .irq_out (irq_out),
    .irq_id  (irq_id)
  );

  typedef struct {
    bit          chk_rd;
    logic [31:0] rd;
    bit          io;
    logic [5:0]  id;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state
  bit          m_ctrl;
  logic [31:0] m_en, m_trig, m_pend, m_act, m_prev;
  int          m_thr;
  int          m_prio [N];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
  endtask

  task automatic m_reset();
    m_ctrl = 0; m_en = 0; m_trig = 0; m_pend = 0; m_act = 0; m_prev = 0; m_thr = 0;
    for (int i = 0; i < N; i++) m_prio[i] = 0;
  endtask

  function automatic int m_winner();
    int best = -1;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i] && !m_act[i] && m_prio[i] > m_thr)
        if (best < 0 || m_prio[i] > m_prio[best]) best = i;
    return best;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [7:0]  wa = a & 8'hFC;
    logic [31:0] v = 0;
    int w;
    case (wa)
      8'h00: v = {31'b0, m_ctrl};
      8'h04: v = m_en;
      8'h08: v = m_pend;
      8'h0C: v = m_trig;
      8'h10: begin w = m_winner(); v = (w >= 0) ? 32'(w + 1) : 32'd0; end
      8'h14: v = m_act;
      8'h18: v = 32'(m_thr);
      default:
        if (wa >= 8'h20)
          for (int n = 0; n < 8; n++) begin
            int s = ((int'(wa) - 32) / 4) * 8 + n;
            if (s < N) v = v | (32'(m_prio[s]) << (4 * n));
          end
    endcase
    return v;
  endfunction

  // One bus cycle: expected outputs come from the model state before the edge.
  task automatic step(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] d);
    int          w;
    exp_t        e;
    logic [7:0]  wa;
    logic [31:0] npend;
    bit          cl;
    bus.rd_en = rd; bus.wr_en = wr; bus.addr = a; bus.wdata = d;
    w = m_winner();
    wa = a & 8'hFC;
    e.chk_rd = rd;
    e.rd     = m_read(a);
    e.io     = m_ctrl && (w >= 0);
    e.id     = (w >= 0) ? 6'(w + 1) : 6'd0;
    @(posedge clk);
    cl = rd && wa == 8'h10 && w >= 0;
    npend = 0;
    for (int i = 0; i < N; i++) begin
      bit p;
      if (m_trig[i]) begin
        p = m_pend[i];
        if (wr && wa == 8'h08 && d[i]) p = 0;
        if (cl && w == i) p = 0;
        if (irq_src[i] && !m_prev[i]) p = 1;
      end else p = irq_src[i];
      if (wr && wa == 8'h0C && d[i] != m_trig[i]) p = 0;
      npend[i] = p;
    end
    m_pend = npend;
    if (wr && wa == 8'h10 && d >= 1 && d <= N) m_act[int'(d) - 1] = 0;
    if (cl) m_act[w] = 1;
    if (wr)
      case (wa)
        8'h00: m_ctrl = d[0];
        8'h04: m_en = d & 32'hFFFF;
        8'h0C: m_trig = d & 32'hFFFF;
        8'h18: m_thr = int'(d[3:0]);
        default:
          if (wa >= 8'h20)
            for (int n = 0; n < 8; n++) begin
              int s = ((int'(wa) - 32) / 4) * 8 + n;
              if (s < N) m_prio[s] = int'((d >> (4 * n)) & 32'hF);
            end
      endcase
    m_prev = 32'(irq_src);
    q.push_back(e);
    #1;
    bus.rd_en = 0; bus.wr_en = 0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d); step(0, 1, a, d); endtask
  task automatic rd_reg(input logic [7:0] a); step(1, 0, a, 32'd0); endtask
  task automatic idle(); step(0, 0, 8'h00, 32'd0); endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("irq_out", 32'(irq_out), 32'(me.io));
      chk("irq_id", 32'(irq_id), 32'(me.id));
      if (me.chk_rd) chk("rdata", bus.rdata, me.rd);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] alist [12];
    logic [7:0] a;
    logic [31:0] d;
    int op;
    alist = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28};
    irq_src = '0;
    bus.addr = 0; bus.wr_en = 0; bus.rd_en = 0; bus.wdata = 0;
    m_reset();
    #12;
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_irq_out", 32'(irq_out), 32'd0);
    chk("reset_irq_id", 32'(irq_id), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Every register reads back zero out of reset
    for (int i = 0; i <= 8; i++) rd_reg(8'(i * 4));

    // Single edge source, claim then EOI
    wr_reg(8'h00, 32'h1);
    wr_reg(8'h04, 32'h0001);
    wr_reg(8'h0C, 32'h0001);
    wr_reg(8'h20, 32'h5);
    irq_src[0] = 1'b1; idle();
    irq_src[0] = 1'b0; idle();
    rd_reg(8'h08);
    rd_reg(8'h10);
    rd_reg(8'h08);
    rd_reg(8'h14);
    idle();
    wr_reg(8'h10, 32'd1);

    // Equal priorities resolve to lowest index
    wr_reg(8'h04, 32'h0024);
    wr_reg(8'h0C, 32'h0024);
    wr_reg(8'h20, 32'h0070_0700);
    irq_src[2] = 1'b1; irq_src[5] = 1'b1; idle();
    irq_src = '0; idle();
    rd_reg(8'h10);
    wr_reg(8'h10, 32'd3);
    rd_reg(8'h10);
    wr_reg(8'h10, 32'd6);
    wr_reg(8'h10, 32'd0);
    wr_reg(8'h10, 32'd40);

    // Threshold gating
    wr_reg(8'h18, 32'd6);
    wr_reg(8'h04, 32'h0002);
    wr_reg(8'h0C, 32'h0002);
    wr_reg(8'h20, 32'h0000_0060);
    irq_src[1] = 1'b1; idle();
    irq_src[1] = 1'b0; idle(); idle();
    wr_reg(8'h20, 32'h0000_0070);
    idle(); idle();
    rd_reg(8'h10);
    wr_reg(8'h10, 32'd2);
    wr_reg(8'h18, 32'd0);

    // Level source ignores W1C
    wr_reg(8'h04, 32'h0010);
    wr_reg(8'h0C, 32'h0000);
    wr_reg(8'h20, 32'h0003_0000);
    irq_src[4] = 1'b1; idle();
    wr_reg(8'h08, 32'h0010);
    rd_reg(8'h08);
    irq_src[4] = 1'b0; idle();
    rd_reg(8'h08);

    // Edge arriving with W1C of the same bit
    wr_reg(8'h0C, 32'h0040);
    wr_reg(8'h04, 32'h0040);
    wr_reg(8'h20, 32'h0200_0000);
    irq_src[6] = 1'b1; wr_reg(8'h08, 32'h0040);
    irq_src[6] = 1'b0; rd_reg(8'h08);
    idle();

    // Asynchronous reset in the middle of a claim
    rd_reg(8'h10);
    @(negedge clk); #1;
    rst_n = 1'b0; irq_src = '0;
    #1;
    chk("async_rst_rdata", bus.rdata, 32'd0);
    chk("async_rst_irq_out", 32'(irq_out), 32'd0);
    chk("async_rst_irq_id", 32'(irq_id), 32'd0);
    m_reset();
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_reg(8'h14);

    // Random traffic
    wr_reg(8'h00, 32'h1);
    for (int c = 0; c < 600; c++) begin
      irq_src = irq_src ^ (N'($urandom) & N'($urandom) & N'($urandom));
      a = alist[$urandom_range(0, 11)] | 8'($urandom_range(0, 3));
      op = $urandom_range(0, 3);
      case (a & 8'hFC)
        8'h10:   d = 32'($urandom_range(0, 18));
        8'h00:   d = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'h1;
        8'h18:   d = 32'($urandom_range(0, 5));
        default: d = $urandom;
      endcase
      step(op[0], op[1], a, d);
    end

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
